// File: rtl/trace_vector_checker.sv
// Compares observed per-cycle trace vectors against a preloaded table of
// expected vectors, with per-channel don't-care, saturating error count,
// first-failure capture and overrun detection.
module trace_vector_checker #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_CH     = 3,
    parameter int DEPTH      = 64,
    parameter int ADDR_W     = 6,
    parameter int ERR_W      = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         load_en,
    input  logic [ADDR_W-1:0]            load_addr,
    input  logic [NUM_CH*DATA_WIDTH-1:0] load_data,
    input  logic [NUM_CH-1:0]            load_care,
    input  logic                         start,
    input  logic [ADDR_W:0]              num_vectors,
    input  logic                         obs_valid,
    input  logic [NUM_CH*DATA_WIDTH-1:0] obs_data,
    output logic                         busy,
    output logic                         done,
    output logic                         pass,
    output logic [ADDR_W:0]              vec_index,
    output logic [ERR_W-1:0]             err_count,
    output logic                         first_err_valid,
    output logic [ADDR_W:0]              first_err_index,
    output logic [NUM_CH-1:0]            first_err_chmask,
    output logic                         overrun
);
    localparam int VW    = NUM_CH * DATA_WIDTH;
    localparam int SUM_W = ERR_W + $clog2(NUM_CH + 1);
    localparam logic [ADDR_W:0]  DEPTH_L = (ADDR_W + 1)'(DEPTH);
    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    state_t state, state_next;

    logic [VW-1:0]     tbl_data [DEPTH];
    logic [NUM_CH-1:0] tbl_care [DEPTH];

    logic [ADDR_W:0]    run_len;
    logic [ADDR_W:0]    start_len;
    logic [VW-1:0]      exp_data;
    logic [NUM_CH-1:0]  exp_care;
    logic [NUM_CH-1:0]  mask;
    logic [SUM_W-1:0]   mask_count;
    logic [SUM_W-1:0]   err_sum;
    logic [ERR_W-1:0]   err_next;
    logic               run_start;
    logic               accept;
    logic               last;

    // Table is a plain register array: no reset, written only outside RUN.
    always_ff @(posedge clock) begin
        if (load_en && state != RUN) begin
            tbl_data[load_addr] <= load_data;
            tbl_care[load_addr] <= load_care;
        end
    end

    always_comb begin
        run_start  = start && (state != RUN);
        accept     = (state == RUN) && obs_valid;
        last       = (vec_index == run_len - (ADDR_W + 1)'(1));
        start_len  = (num_vectors > DEPTH_L) ? DEPTH_L : num_vectors;
        exp_data   = tbl_data[vec_index[ADDR_W-1:0]];
        exp_care   = tbl_care[vec_index[ADDR_W-1:0]];
        mask       = '0;
        mask_count = '0;
        for (int unsigned c = 0; c < NUM_CH; c++) begin
            if (exp_care[c] &&
                obs_data[c*DATA_WIDTH +: DATA_WIDTH] != exp_data[c*DATA_WIDTH +: DATA_WIDTH]) begin
                mask[c]    = 1'b1;
                mask_count = mask_count + SUM_W'(1);
            end
        end
        // Sum is computed wide so saturation can be detected without wrapping.
        err_sum  = SUM_W'(err_count) + mask_count;
        err_next = (err_sum > SUM_W'(ERR_MAX)) ? ERR_MAX : err_sum[ERR_W-1:0];
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        pass       = 1'b0;
        case (state)
            IDLE: begin
                if (start) state_next = (num_vectors == '0) ? DONE : RUN;
            end
            RUN: begin
                busy = 1'b1;
                if (obs_valid && last) state_next = DONE;
            end
            DONE: begin
                done = 1'b1;
                pass = (err_count == '0) && !overrun;
                if (start) state_next = (num_vectors == '0) ? DONE : RUN;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            run_len          <= '0;
            vec_index        <= '0;
            err_count        <= '0;
            first_err_valid  <= 1'b0;
            first_err_index  <= '0;
            first_err_chmask <= '0;
            overrun          <= 1'b0;
        end else if (run_start) begin
            run_len          <= start_len;
            vec_index        <= '0;
            err_count        <= '0;
            first_err_valid  <= 1'b0;
            first_err_index  <= '0;
            first_err_chmask <= '0;
            overrun          <= 1'b0;
        end else if (accept) begin
            vec_index <= vec_index + (ADDR_W + 1)'(1);
            err_count <= err_next;
            if (mask != '0 && !first_err_valid) begin
                first_err_valid  <= 1'b1;
                first_err_index  <= vec_index;
                first_err_chmask <= mask;
            end
        end else if (state == DONE && obs_valid) begin
            overrun <= 1'b1;
        end
    end
endmodule

// File: tb/tb_trace_vector_checker.sv
// Scoreboard bench for trace_vector_checker: randomized and directed runs
// against a behavioural model, on a wide-counter and a 2-bit-counter instance.
module tb_trace_vector_checker;
    localparam int DW  = 32;
    localparam int NC  = 3;
    localparam int DEP = 64;
    localparam int AW  = 6;
    localparam int VW  = NC * DW;

    logic          clock = 1'b0;
    logic          reset;
    logic          load_en;
    logic [AW-1:0] load_addr;
    logic [VW-1:0] load_data;
    logic [NC-1:0] load_care;
    logic          start;
    logic [AW:0]   num_vectors;
    logic          obs_valid;
    logic [VW-1:0] obs_data;

    logic          busy, done, pass, first_err_valid, overrun;
    logic [AW:0]   vec_index, first_err_index;
    logic [15:0]   err_count;
    logic [NC-1:0] first_err_chmask;

    logic          s_busy, s_done, s_pass, s_first_err_valid, s_overrun;
    logic [AW:0]   s_vec_index, s_first_err_index;
    logic [1:0]    s_err_count;
    logic [NC-1:0] s_first_err_chmask;

    always #5 clock = ~clock;

    trace_vector_checker #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEP), .ADDR_W(AW), .ERR_W(16)) u_dut (
        .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_care(load_care), .start(start), .num_vectors(num_vectors),
        .obs_valid(obs_valid), .obs_data(obs_data), .busy(busy), .done(done), .pass(pass),
        .vec_index(vec_index), .err_count(err_count), .first_err_valid(first_err_valid),
        .first_err_index(first_err_index), .first_err_chmask(first_err_chmask), .overrun(overrun)
    );

    trace_vector_checker #(.DATA_WIDTH(DW), .NUM_CH(NC), .DEPTH(DEP), .ADDR_W(AW), .ERR_W(2)) u_sat (
        .clock(clock), .reset(reset), .load_en(load_en), .load_addr(load_addr),
        .load_data(load_data), .load_care(load_care), .start(start), .num_vectors(num_vectors),
        .obs_valid(obs_valid), .obs_data(obs_data), .busy(s_busy), .done(s_done), .pass(s_pass),
        .vec_index(s_vec_index), .err_count(s_err_count), .first_err_valid(s_first_err_valid),
        .first_err_index(s_first_err_index), .first_err_chmask(s_first_err_chmask),
        .overrun(s_overrun)
    );

    typedef struct {
        int busy, done, pass, idx, err16, err2, fev, fei, fem, ovr;
    } snap_t;

    snap_t exp_q[$];
    int total = 0;
    int bad   = 0;

    // Behavioural reference: plain counters, unbounded error tally.
    logic [VW-1:0] m_tbl  [DEP];
    logic [NC-1:0] m_care [DEP];
    int m_mode;  // 0 idle, 1 running, 2 finished
    int m_len, m_idx, m_err, m_fev, m_fei, m_fem, m_ovr;

    function automatic logic [VW-1:0] pack3(input logic [31:0] a, input logic [31:0] b,
                                            input logic [31:0] c);
        return {c, b, a};
    endfunction

    function automatic snap_t model_snap();
        snap_t s;
        s.busy  = (m_mode == 1) ? 1 : 0;
        s.done  = (m_mode == 2) ? 1 : 0;
        s.pass  = (m_mode == 2 && m_err == 0 && m_ovr == 0) ? 1 : 0;
        s.idx   = m_idx;
        s.err16 = (m_err > 65535) ? 65535 : m_err;
        s.err2  = (m_err > 3) ? 3 : m_err;
        s.fev   = m_fev;
        s.fei   = m_fei;
        s.fem   = m_fem;
        s.ovr   = m_ovr;
        return s;
    endfunction

    task automatic model_reset();
        m_mode = 0; m_len = 0; m_idx = 0; m_err = 0;
        m_fev = 0; m_fei = 0; m_fem = 0; m_ovr = 0;
    endtask

    task automatic model_apply(input bit le, input int la, input logic [VW-1:0] ld,
                               input logic [NC-1:0] lc, input bit st, input int nv,
                               input bit ov, input logic [VW-1:0] od);
        logic [VW-1:0] e;
        int cnt;
        int mk;
        if (le && m_mode != 1) begin
            m_tbl[la]  = ld;
            m_care[la] = lc;
        end
        if (st && m_mode != 1) begin
            m_len = (nv > DEP) ? DEP : nv;
            m_idx = 0; m_err = 0; m_fev = 0; m_fei = 0; m_fem = 0; m_ovr = 0;
            m_mode = (m_len == 0) ? 2 : 1;
        end else if (m_mode == 1 && ov) begin
            e   = m_tbl[m_idx];
            cnt = 0;
            mk  = 0;
            for (int c = 0; c < NC; c++) begin
                if (m_care[m_idx][c] && od[c*DW +: DW] != e[c*DW +: DW]) begin
                    mk  = mk + (1 << c);
                    cnt = cnt + 1;
                end
            end
            m_err = m_err + cnt;
            if (mk != 0 && m_fev == 0) begin
                m_fev = 1; m_fei = m_idx; m_fem = mk;
            end
            m_idx = m_idx + 1;
            if (m_idx == m_len) m_mode = 2;
        end else if (m_mode == 2 && ov) begin
            m_ovr = 1;
        end
    endtask

    task automatic chk(input string name, input int act, input int expv);
        total = total + 1;
        if (act != expv) begin
            bad = bad + 1;
            $display("FAIL %s at %0t: got %0d expected %0d", name, $time, act, expv);
        end
    endtask

    // Monitor: compares each pending expectation away from the active edge.
    initial begin
        snap_t s;
        forever begin
            @(negedge clock or negedge reset);
            #1;
            while (exp_q.size() > 0) begin
                s = exp_q.pop_front();
                chk("busy",             int'(busy),             s.busy);
                chk("done",             int'(done),             s.done);
                chk("pass",             int'(pass),             s.pass);
                chk("vec_index",        int'(vec_index),        s.idx);
                chk("err_count",        int'(err_count),        s.err16);
                chk("first_err_valid",  int'(first_err_valid),  s.fev);
                chk("first_err_index",  int'(first_err_index),  s.fei);
                chk("first_err_chmask", int'(first_err_chmask), s.fem);
                chk("overrun",          int'(overrun),          s.ovr);
                chk("sat_err_count",    int'(s_err_count),      s.err2);
                chk("sat_pass",         int'(s_pass),           s.pass);
            end
        end
    end

    task automatic step(input bit le, input int la, input logic [VW-1:0] ld,
                        input logic [NC-1:0] lc, input bit st, input int nv,
                        input bit ov, input logic [VW-1:0] od);
        load_en     = le;
        load_addr   = la[AW-1:0];
        load_data   = ld;
        load_care   = lc;
        start       = st;
        num_vectors = nv[AW:0];
        obs_valid   = ov;
        obs_data    = od;
        model_apply(le, la, ld, lc, st, nv, ov, od);
        @(posedge clock);
        #1;
        exp_q.push_back(model_snap());
        load_en   = 1'b0;
        start     = 1'b0;
        obs_valid = 1'b0;
    endtask

    task automatic idle();
        step(1'b0, 0, '0, '0, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic load(input int a, input logic [VW-1:0] d, input logic [NC-1:0] c);
        step(1'b1, a, d, c, 1'b0, 0, 1'b0, '0);
    endtask

    task automatic begin_run(input int nv);
        step(1'b0, 0, '0, '0, 1'b1, nv, 1'b0, '0);
    endtask

    task automatic obs(input logic [VW-1:0] d);
        step(1'b0, 0, '0, '0, 1'b0, 0, 1'b1, d);
    endtask

    initial begin
        logic [VW-1:0] v0, v1, v2, od, junk;
        int nv;
        v0 = pack3(32'h28400005, 32'h0, 32'h5);
        v1 = pack3(32'h28800003, 32'h0, 32'h3);
        v2 = pack3(32'h00C22000, 32'h5, 32'h3);

        reset = 1'b0; load_en = 1'b0; load_addr = '0; load_data = '0; load_care = '0;
        start = 1'b0; num_vectors = '0; obs_valid = 1'b0; obs_data = '0;
        model_reset();
        @(negedge clock);
        exp_q.push_back(model_snap());
        #2 reset = 1'b1;
        @(posedge clock);
        #1;

        for (int i = 0; i < DEP; i++) load(i, {$urandom(), $urandom(), $urandom()}, 3'b111);

        // Clean three-vector run
        load(0, v0, 3'b111); load(1, v1, 3'b111); load(2, v2, 3'b111);
        begin_run(3);
        obs(v0); obs(v1); obs(v2);
        idle();

        // Mismatches on vectors 1 and 2
        begin_run(3);
        obs(v0);
        obs(pack3(32'h28800003, 32'h7, 32'h4));
        obs(pack3(32'h0, 32'h5, 32'h3));
        idle();

        // Don't-care channels
        load(0, v0, 3'b001);
        begin_run(1);
        obs(pack3(32'h28400005, 32'hDEAD, 32'hBEEF));
        idle();

        // Gaps between vectors, then overrun
        load(0, v0, 3'b111); load(1, v1, 3'b111);
        begin_run(2);
        obs(v0);
        repeat (3) idle();
        obs(v1);
        repeat (5) idle();
        obs(v0);
        idle();

        // All-channel mismatches exceed the 2-bit counter; then empty run
        begin_run(2);
        obs(~v0); obs(~v1);
        idle();
        begin_run(0);
        idle();

        // Load and start together: entry 0 written on the start edge is used
        step(1'b1, 0, v2, 3'b111, 1'b1, 1, 1'b0, '0);
        obs(v2);
        idle();

        // Asynchronous reset mid-run at vec_index 1
        begin_run(3);
        obs(v2);
        @(negedge clock);
        #2;
        model_reset();
        exp_q.push_back(model_snap());
        reset = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        idle();

        // Loads and start during a run are ignored; rerun matches
        load(0, v0, 3'b111); load(1, v1, 3'b111); load(2, v2, 3'b111);
        begin_run(3);
        obs(v0);
        step(1'b1, 1, ~v1, 3'b111, 1'b1, 1, 1'b0, '0);
        step(1'b1, 2, ~v2, 3'b111, 1'b0, 0, 1'b1, v1);
        obs(v2);
        begin_run(3);
        obs(v0); obs(v1); obs(v2);
        idle();

        // Randomized runs
        for (int r = 0; r < 40; r++) begin
            for (int k = 0; k < int'($urandom_range(0, 3)); k++)
                load($urandom_range(0, 7), {$urandom(), $urandom(), $urandom()},
                     3'($urandom_range(0, 7)));
            nv = ($urandom_range(0, 9) == 0) ? 70 : int'($urandom_range(0, 8));
            if ($urandom_range(0, 3) == 0)
                step(1'b1, 0, {$urandom(), $urandom(), $urandom()}, 3'b111, 1'b1, nv, 1'b0, '0);
            else
                begin_run(nv);
            for (int k = 0; k < 300 && m_mode == 1; k++) begin
                if ($urandom_range(0, 3) == 0) begin
                    junk = {$urandom(), $urandom(), $urandom()};
                    step($urandom_range(0, 1) == 1, $urandom_range(0, 7), junk, 3'b111,
                         $urandom_range(0, 1) == 1, $urandom_range(0, 8), 1'b0, '0);
                end else begin
                    od = m_tbl[m_idx];
                    for (int c = 0; c < NC; c++)
                        if ($urandom_range(0, 3) == 0) od[c*DW +: DW] = od[c*DW +: DW] ^ ($urandom() | 32'h1);
                    obs(od);
                end
            end
            if ($urandom_range(0, 2) == 0) obs({$urandom(), $urandom(), $urandom()});
            idle();
        end

        repeat (3) idle();
        @(negedge clock);
        #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
